// File: rtl/iiitb_fifo_pkg.sv
// Shared types and defaults for the iiitb_fifo single-clock byte FIFO.
// Build option: IIITB_FIFO_OCCUPANCY_EN exposes the occupancy count on the top level.
package iiitb_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 16;

    typedef logic [7:0] data_t;

    // Per-cycle operation actually carried out, after full/empty qualification.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

    function automatic fifo_op_t decode_op(input logic push_ok, input logic pop_ok);
        return fifo_op_t'({pop_ok, push_ok});
    endfunction

endpackage

// File: rtl/iiitb_fifo_mem.sv
// Storage array for iiitb_fifo: DEPTH x DATA_WIDTH registers, one synchronous
// write port and one combinational read port. Contents are never reset.
module iiitb_fifo_mem
    import iiitb_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                      clock,
    input  logic                      wr_en,
    input  logic [$clog2(DEPTH)-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/iiitb_fifo.sv
// Synchronous single-clock FIFO with registered read data and full/empty flags.
// Build option: define IIITB_FIFO_OCCUPANCY_EN to add the fifo_Count output.
module iiitb_fifo
    import iiitb_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    write_Enable,
    input  logic                    read_Enable,
    input  logic [DATA_WIDTH-1:0]   buffer_Input,
    output logic [DATA_WIDTH-1:0]   buffer_Output,
    output logic                    sig_Full,
`ifdef IIITB_FIFO_OCCUPANCY_EN
    output logic                    sig_Empty,
    output logic [$clog2(DEPTH):0]  fifo_Count
`else
    output logic                    sig_Empty
`endif
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_next;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  push_ok;
    logic                  pop_ok;
    fifo_op_t              op;
    logic [DATA_WIDTH-1:0] rd_data;

    // Flags decode only the registered count, so inputs never reach them.
    assign sig_Full  = (count == FULL_COUNT);
    assign sig_Empty = (count == '0);

    // Qualify requests against pre-edge flags and work out the next pointer/count state.
    // DEPTH is a power of two, so pointer increment wraps to 0 after DEPTH-1 naturally.
    always_comb begin
        push_ok     = write_Enable & ~sig_Full;
        pop_ok      = read_Enable & ~sig_Empty;
        op          = decode_op(push_ok, pop_ok);
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        case (op)
            OP_PUSH: begin
                wr_ptr_next = wr_ptr + 1'b1;
                count_next  = count + 1'b1;
            end
            OP_POP: begin
                rd_ptr_next = rd_ptr + 1'b1;
                count_next  = count - 1'b1;
            end
            OP_BOTH: begin
                wr_ptr_next = wr_ptr + 1'b1;
                rd_ptr_next = rd_ptr + 1'b1;
            end
            default: ;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
        end
    end

    // Registered read data: loads on an accepted pop, otherwise holds.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buffer_Output <= '0;
        end else if (pop_ok) begin
            buffer_Output <= rd_data;
        end
    end

    iiitb_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (buffer_Input),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

`ifdef IIITB_FIFO_OCCUPANCY_EN
    assign fifo_Count = count;
`endif

endmodule

// File: tb/tb_iiitb_fifo.sv
// Scoreboard bench for iiitb_fifo: directed steps queue their hand-computed
// expected outputs; a monitor pops and compares on each falling clock edge.
module tb_iiitb_fifo;

    logic       clock;
    logic       reset;
    logic       write_Enable;
    logic       read_Enable;
    logic [7:0] buffer_Input;
    logic [7:0] buffer_Output;
    logic       sig_Full;
    logic       sig_Empty;
`ifdef IIITB_FIFO_OCCUPANCY_EN
    logic [4:0] fifo_Count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] out;
        logic       full;
        logic       empty;
        logic [4:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    event  chk_ev;

    iiitb_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .write_Enable  (write_Enable),
        .read_Enable   (read_Enable),
        .buffer_Input  (buffer_Input),
        .buffer_Output (buffer_Output),
        .sig_Full      (sig_Full),
`ifdef IIITB_FIFO_OCCUPANCY_EN
        .sig_Empty     (sig_Empty),
        .fifo_Count    (fifo_Count)
`else
        .sig_Empty     (sig_Empty)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cmp(input string tag, input string field,
                       input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, field, act, req);
        end
    endtask

    task automatic expect_state(input logic [7:0] eo, input logic ef, input logic ee,
                                input logic [4:0] ec, input string tag);
        exp_t e;
        e.out   = eo;
        e.full  = ef;
        e.empty = ee;
        e.cnt   = ec;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Drive one cycle of stimulus, then queue the state expected after that edge.
    task automatic step(input logic we, input logic re, input logic [7:0] din,
                        input logic [7:0] eo, input logic ef, input logic ee,
                        input logic [4:0] ec, input string tag);
        write_Enable = we;
        read_Enable  = re;
        buffer_Input = din;
        @(posedge clock);
        #1;
        expect_state(eo, ef, ee, ec, tag);
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    initial begin
        forever begin
            @(negedge clock or chk_ev);
            while (exp_q.size() != 0) begin
                exp_t  e;
                string t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                cmp(t, "out",   buffer_Output,    e.out);
                cmp(t, "full",  {7'd0, sig_Full},  {7'd0, e.full});
                cmp(t, "empty", {7'd0, sig_Empty}, {7'd0, e.empty});
`ifdef IIITB_FIFO_OCCUPANCY_EN
                cmp(t, "count", {3'd0, fifo_Count}, {3'd0, e.cnt});
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        write_Enable = 1'b1;
        read_Enable  = 1'b0;
        buffer_Input = 8'h01;

        // Held in reset with a write pending: nothing may be accepted.
        repeat (2) step(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 5'd0, "reset_hold");
        reset = 1'b1;

        // Fill with 1..16, then a dropped write while full.
        for (int i = 1; i <= 16; i++)
            step(1'b1, 1'b0, 8'(i), 8'h00, (i == 16), 1'b0, 5'(i), "fill");
        step(1'b1, 1'b0, 8'hAA, 8'h00, 1'b1, 1'b0, 5'd16, "write_full_drop");

        // Drain in order, then a read while empty holds the last byte.
        for (int i = 1; i <= 16; i++)
            step(1'b0, 1'b1, 8'h00, 8'(i), 1'b0, (i == 16), 5'(16 - i), "drain");
        step(1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 1'b1, 5'd0, "read_empty_hold");

        // Occupancy 5, then stream 0x25..0x3F with push+pop every cycle across the wrap.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 8'(8'h20 + i), 8'h10, 1'b0, 1'b0, 5'(i + 1), "prefill5");
        for (int j = 0; j < 27; j++)
            step(1'b1, 1'b1, 8'(8'h25 + j), 8'(8'h20 + j), 1'b0, 1'b0, 5'd5, "stream");

        // Refill to full (0x3B..0x3F already held), then push+pop at full.
        for (int i = 0; i < 11; i++)
            step(1'b1, 1'b0, 8'(8'h40 + i), 8'h3A, (i == 10), 1'b0, 5'(6 + i), "refill");
        step(1'b1, 1'b1, 8'hBB, 8'h3B, 1'b0, 1'b0, 5'd15, "both_at_full");

        // Drain; 0xBB must never appear.
        for (int k = 0; k < 15; k++)
            step(1'b0, 1'b1, 8'h00,
                 (k < 4) ? 8'(8'h3C + k) : 8'(8'h40 + k - 4),
                 1'b0, (k == 14), 5'(14 - k), "drain_after_full");

        // Push+pop at empty: only the write happens, output holds.
        step(1'b1, 1'b1, 8'hCC, 8'h4A, 1'b0, 1'b0, 5'd1, "both_at_empty");
        step(1'b0, 1'b1, 8'h00, 8'hCC, 1'b0, 1'b1, 5'd0, "pop_cc");

        // Load 7 entries, then assert reset between edges.
        for (int i = 0; i < 7; i++)
            step(1'b1, 1'b0, 8'(8'h50 + i), 8'hCC, 1'b0, 1'b0, 5'(i + 1), "load7");
        @(negedge clock);
        #2;
        write_Enable = 1'b0;
        read_Enable  = 1'b0;
        reset        = 1'b0;
        #1;
        expect_state(8'h00, 1'b0, 1'b1, 5'd0, "async_reset");
        ->chk_ev;

        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 5'd0, "reset_held");
        reset = 1'b1;
        step(1'b1, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0, 5'd1, "post_reset_write");
        step(1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 1'b1, 5'd0, "post_reset_read");

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
